sr_ff_bank: RTL

//  Parametrised bank of N clocked SR storage elements with a shared enable.

---
 rtl/sr_ff_bank.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sr_ff_bank
//  Description : Bank of N edge-triggered SR storage elements with a shared
//                update enable. The S=R=1 case is resolved by the MODE
//                parameter. Every S=R=1 event is flagged for one cycle on its
//                channel and counted in a saturating error counter.
//
//  Parameters  : N       - number of channels (1..32)
//                MODE    - S=R=1 resolution: 0 set-dominant, 1 reset-dominant,
//                          2 hold, 3 toggle; any other value behaves as 2
//                RST_VAL - value loaded into q on reset
//                CNT_W   - width of err_cnt (>= clog2(N+1))
//
//  Ports       : clk        in   1      rising-edge clock
//                rst        in   1      synchronous active-high reset
//                en         in   1      update enable (0 = all channels hold)
//                s          in   N      per-channel set request
//                r          in   N      per-channel reset request
//                clr_err    in   1      clears err_sticky and err_cnt
//                q          out  N      stored state (registered)
//                qbar       out  N      exact complement of q
//                invalid    out  N      one-cycle pulse per S=R=1 event
//                err_sticky out  1      any invalid event since last clear
//                err_cnt    out  CNT_W  saturating count of invalid events
//
//  Revision    : 1.0  initial release
// ============================================================================
module sr_ff_bank #(
    parameter int           N       = 8,
    parameter int           MODE    = 0,
    parameter logic [N-1:0] RST_VAL = '0,
    parameter int           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    input  logic             clr_err,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qbar,
    output logic [N-1:0]     invalid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    // Width needed to hold a popcount of up to N events.
    localparam int c_KW = $clog2(N + 1);

    // Out-of-range MODE values collapse onto the hold behaviour.
    localparam int c_MODE_EFF = ((MODE >= 0) && (MODE <= 3)) ? MODE : 2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [N-1:0]     state_q,   state_d;
    logic [N-1:0]     invalid_q, invalid_d;
    logic             sticky_q,  sticky_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [N-1:0]     w_ev;
    logic [c_KW-1:0]  w_k;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W:0]   w_cnt_sum;

    // ------------------------------------------------------------------
    // Per-channel next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                unique case ({s[i], r[i]})
                    2'b10:   state_d[i] = 1'b1;
                    2'b01:   state_d[i] = 1'b0;
                    2'b11: begin
                        case (c_MODE_EFF)
                            0:       state_d[i] = 1'b1;
                            1:       state_d[i] = 1'b0;
                            3:       state_d[i] = ~state_q[i];
                            default: state_d[i] = state_q[i];
                        endcase
                    end
                    default: state_d[i] = state_q[i];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Event detection and error accounting
    // ------------------------------------------------------------------
    always_comb begin
        w_ev = {N{en}} & s & r;
        invalid_d = w_ev;

        w_k = '0;
        for (int i = 0; i < N; i++) begin
            w_k = w_k + c_KW'(w_ev[i]);
        end

        // A clear restarts the count from zero, but events on the same edge
        // are still accumulated so none are lost.
        w_cnt_base = clr_err ? '0 : cnt_q;

        // One extra bit of headroom makes the overflow check exact.
        w_cnt_sum = {1'b0, w_cnt_base} + {{(CNT_W + 1 - c_KW){1'b0}}, w_k};
        cnt_d     = w_cnt_sum[CNT_W] ? c_CNT_MAX : w_cnt_sum[CNT_W-1:0];

        sticky_d  = (clr_err ? 1'b0 : sticky_q) | (w_k != '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_VAL;
            invalid_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            invalid_q <= invalid_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q          = state_q;
    assign qbar       = ~state_q;
    assign invalid    = invalid_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule
`default_nettype wire
